// File: rtl/ein_rx_if.sv
// FIFO write port of the EIN receiver: byte, write strobe and the full flag back.
interface ein_rx_if;
  logic [7:0] fifo_dout;
  logic       fifo_WE;
  logic       fifo_full;

  modport master (output fifo_dout, output fifo_WE, input fifo_full);
  modport slave  (input fifo_dout, input fifo_WE, output fifo_full);
endinterface

// File: rtl/ein_rx.sv
// EIN serial link receiver: synchronizes EMO/ECI/EDI, assembles LSB-first bytes
// and writes them to the downstream FIFO, reporting frame status.
module ein_rx #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             EMO_IN,
  input  logic             ECI_IN,
  input  logic             EDI_IN,
  ein_rx_if.master         fifo,
  output logic             rx_active,
  output logic             frame_done,
  output logic [CNT_W-1:0] byte_count,
  output logic             partial_err,
  output logic             overflow
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  logic emo_s1_q, emo_s2_q;
  logic eci_s1_q, eci_s2_q, eci_s3_q;
  logic edi_s1_q, edi_s2_q;

  state_e           state_q, state_d;
  logic [1:0]       prime_q, prime_d;
  logic [2:0]       bit_ctr_q, bit_ctr_d;
  logic [7:0]       shift_q, shift_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       dout_q, dout_d;
  logic             we_q, we_d;
  logic             frame_done_q, frame_done_d;
  logic             partial_err_q, partial_err_d;

  logic eci_rise;
  assign eci_rise = eci_s2_q & ~eci_s3_q;

  // NOTE: all state, including the synchronizer chain and the shift register,
  // is reset, so the block comes out of reset in a fully defined condition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      emo_s1_q      <= 1'b0;
      emo_s2_q      <= 1'b0;
      eci_s1_q      <= 1'b0;
      eci_s2_q      <= 1'b0;
      eci_s3_q      <= 1'b0;
      edi_s1_q      <= 1'b0;
      edi_s2_q      <= 1'b0;
      state_q       <= WAIT_IDLE;
      prime_q       <= 2'd0;
      bit_ctr_q     <= 3'd0;
      shift_q       <= 8'h00;
      byte_count_q  <= '0;
      overflow_q    <= 1'b0;
      dout_q        <= 8'h00;
      we_q          <= 1'b0;
      frame_done_q  <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the s1->s2->s3 chain a real pipeline.
      emo_s1_q      <= EMO_IN;
      emo_s2_q      <= emo_s1_q;
      eci_s1_q      <= ECI_IN;
      eci_s2_q      <= eci_s1_q;
      eci_s3_q      <= eci_s2_q;
      edi_s1_q      <= EDI_IN;
      edi_s2_q      <= edi_s1_q;
      state_q       <= state_d;
      prime_q       <= prime_d;
      bit_ctr_q     <= bit_ctr_d;
      shift_q       <= shift_d;
      byte_count_q  <= byte_count_d;
      overflow_q    <= overflow_d;
      dout_q        <= dout_d;
      we_q          <= we_d;
      frame_done_q  <= frame_done_d;
      partial_err_q <= partial_err_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d       = state_q;
    prime_d       = prime_q;
    bit_ctr_d     = bit_ctr_q;
    shift_d       = shift_q;
    byte_count_d  = byte_count_q;
    overflow_d    = overflow_q;
    dout_d        = dout_q;
    we_d          = 1'b0;
    frame_done_d  = 1'b0;
    partial_err_d = 1'b0;

    // The synchronizers reset to 0, so emo_s2 only reflects the pin once the
    // chain has refilled; until then a frame still in progress looks idle.
    if (prime_q != 2'd2) prime_d = prime_q + 2'd1;

    unique case (state_q)
      WAIT_IDLE: begin
        if (prime_q == 2'd2 && !emo_s2_q) state_d = IDLE;
      end
      IDLE: begin
        if (emo_s2_q) begin
          state_d      = ACTIVE;
          bit_ctr_d    = 3'd0;
          shift_d      = 8'h00;
          byte_count_d = '0;
          overflow_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (!emo_s2_q) begin
          // Frame end takes priority over a coincident ECI edge.
          state_d       = IDLE;
          frame_done_d  = 1'b1;
          partial_err_d = (bit_ctr_q != 3'd0);
        end else if (eci_rise) begin
          shift_d[bit_ctr_q] = edi_s2_q;
          bit_ctr_d          = bit_ctr_q + 3'd1;
          if (bit_ctr_q == 3'd7) begin
            if (!fifo.fifo_full) begin
              dout_d = {edi_s2_q, shift_q[6:0]};
              we_d   = 1'b1;
              if (byte_count_q != {CNT_W{1'b1}}) byte_count_d = byte_count_q + CNT_W'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign fifo.fifo_dout = dout_q;
  assign fifo.fifo_WE   = we_q;
  assign rx_active      = (state_q == ACTIVE);
  assign frame_done     = frame_done_q;
  assign partial_err    = partial_err_q;
  assign byte_count     = byte_count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_ein_rx.sv
// Directed self-checking bench for ein_rx: drives EIN line waveforms and checks
// FIFO writes, frame status pulses and their cycle timing against fixed values.
module tb_ein_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        emo = 1'b0;
  logic        eci = 1'b0;
  logic        edi = 1'b0;
  logic        rx_active, frame_done, partial_err, overflow;
  logic [15:0] byte_count;

  ein_rx_if fifo ();

  ein_rx #(.CNT_W(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .EMO_IN      (emo),
    .ECI_IN      (eci),
    .EDI_IN      (edi),
    .fifo        (fifo),
    .rx_active   (rx_active),
    .frame_done  (frame_done),
    .byte_count  (byte_count),
    .partial_err (partial_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = 0;

  // Monitor state (written only by the monitor process).
  logic [7:0] wr_q[$];
  int         we_cyc_q[$];
  int         fd_cnt = 0;
  int         fd_cyc = 0;
  int         pe_cnt = 0;
  int         pe_fd_cnt = 0;
  int         consec = 0;
  logic       we_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fifo.fifo_WE === 1'b1) begin
      wr_q.push_back(fifo.fifo_dout);
      we_cyc_q.push_back(cyc);
      if (we_prev) consec++;
    end
    we_prev = (fifo.fifo_WE === 1'b1);
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (partial_err === 1'b1) begin
      pe_cnt++;
      if (frame_done === 1'b1) pe_fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ECI period: 4 cycles low (EDI set up), 4 cycles high.
  task automatic send_bit(input logic b, input logic full_hi);
    eci = 1'b0;
    edi = b;
    tick(4);
    eci = 1'b1;
    fifo.fifo_full = full_hi;
    rise_cyc = cyc + 1;
    tick(4);
    fifo.fifo_full = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic full_b7);
    for (int i = 0; i < 8; i++) send_bit(v[i], full_b7 && (i == 7));
  endtask

  task automatic start_frame();
    emo = 1'b1;
    tick(4);
  endtask

  task automatic end_frame();
    tick(2);
    eci = 1'b0;
    tick(2);
    emo = 1'b0;
    fall_cyc = cyc + 1;
    tick(6);
  endtask

  int base_wr, base_fd, base_pe, base_pfd;
  int g0, g1;

  initial begin
    fifo.fifo_full = 1'b0;

    // Reset values
    tick(3);
    check("rst_dout", fifo.fifo_dout, 8'h00);
    check("rst_we", fifo.fifo_WE, 1'b0);
    check("rst_active", rx_active, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_perr", partial_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_bcnt", byte_count, 16'd0);
    resetn = 1'b1;
    tick(6);

    // Single byte 0xA5, with rx_active and fifo_WE / frame_done timing
    base_wr = wr_q.size(); base_fd = fd_cnt; base_pe = pe_cnt;
    emo = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("act_early", rx_active, 1'b0);
    @(posedge clk);
    #1 check("act_rise", rx_active, 1'b1);
    tick(2);
    send_byte(8'hA5, 1'b0);
    tick(2);
    check("t1_nwr", wr_q.size() - base_wr, 1);
    check("t1_byte", wr_q[base_wr], 8'hA5);
    check("t1_we_lat", we_cyc_q[base_wr], rise_cyc + 2);
    end_frame();
    check("t1_fd", fd_cnt - base_fd, 1);
    check("t1_fd_lat", fd_cyc, fall_cyc + 2);
    check("t1_pe", pe_cnt - base_pe, 0);
    check("t1_bcnt", byte_count, 16'd1);
    check("t1_idle", rx_active, 1'b0);

    // Multi-byte order and write spacing
    base_wr = wr_q.size(); base_fd = fd_cnt; base_pe = pe_cnt;
    start_frame();
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b0);
    send_byte(8'hFF, 1'b0);
    end_frame();
    check("t2_nwr", wr_q.size() - base_wr, 3);
    check("t2_b0", wr_q[base_wr], 8'h01);
    check("t2_b1", wr_q[base_wr+1], 8'h80);
    check("t2_b2", wr_q[base_wr+2], 8'hFF);
    g0 = we_cyc_q[base_wr+1] - we_cyc_q[base_wr];
    g1 = we_cyc_q[base_wr+2] - we_cyc_q[base_wr+1];
    check("t2_gap", (g0 >= 64 && g1 >= 64), 1'b1);
    check("t2_bcnt", byte_count, 16'd3);
    check("t2_fd", fd_cnt - base_fd, 1);
    check("t2_pe", pe_cnt - base_pe, 0);

    // Partial byte: 0x3C then 3 bits
    base_wr = wr_q.size(); base_fd = fd_cnt; base_pe = pe_cnt; base_pfd = pe_fd_cnt;
    start_frame();
    send_byte(8'h3C, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    end_frame();
    check("t3_nwr", wr_q.size() - base_wr, 1);
    check("t3_byte", wr_q[base_wr], 8'h3C);
    check("t3_fd", fd_cnt - base_fd, 1);
    check("t3_pe", pe_cnt - base_pe, 1);
    check("t3_pe_with_fd", pe_fd_cnt - base_pfd, 1);
    check("t3_bcnt", byte_count, 16'd1);

    // Overflow on byte 2
    base_wr = wr_q.size();
    start_frame();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    check("t4_ovf_mid", overflow, 1'b1);
    send_byte(8'h33, 1'b0);
    end_frame();
    check("t4_nwr", wr_q.size() - base_wr, 2);
    check("t4_b0", wr_q[base_wr], 8'h11);
    check("t4_b1", wr_q[base_wr+1], 8'h33);
    check("t4_ovf", overflow, 1'b1);
    check("t4_bcnt", byte_count, 16'd2);

    // ECI already high when EMO rises; new frame also clears overflow
    base_wr = wr_q.size(); base_pe = pe_cnt;
    edi = 1'b1;
    eci = 1'b1;
    tick(4);
    start_frame();
    check("t5_ovf_clr", overflow, 1'b0);
    check("t5_bcnt_clr", byte_count, 16'd0);
    send_byte(8'h5A, 1'b0);
    end_frame();
    check("t5_nwr", wr_q.size() - base_wr, 1);
    check("t5_byte", wr_q[base_wr], 8'h5A);
    check("t5_pe", pe_cnt - base_pe, 0);

    // Reset mid-frame with EMO held high
    base_wr = wr_q.size(); base_fd = fd_cnt;
    start_frame();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    eci = 1'b0;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    send_byte(8'hFF, 1'b0);
    tick(4);
    check("t6_nwr_hi", wr_q.size() - base_wr, 0);
    check("t6_active", rx_active, 1'b0);
    check("t6_bcnt", byte_count, 16'd0);
    end_frame();
    check("t6_fd", fd_cnt - base_fd, 0);
    start_frame();
    send_byte(8'hC3, 1'b0);
    end_frame();
    check("t6_nwr", wr_q.size() - base_wr, 1);
    check("t6_byte", wr_q[base_wr], 8'hC3);
    check("t6_fd_new", fd_cnt - base_fd, 1);
    check("t6_bcnt_new", byte_count, 16'd1);

    // ECI toggling with EMO low
    base_wr = wr_q.size(); base_fd = fd_cnt;
    send_byte(8'hFF, 1'b0);
    eci = 1'b0;
    tick(6);
    check("t7_nwr", wr_q.size() - base_wr, 0);
    check("t7_fd", fd_cnt - base_fd, 0);
    check("t7_active", rx_active, 1'b0);

    check("no_back_to_back_we", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
